// File: rtl/mouse_pkg.sv
// ============================================================================
// Module      : mouse_pkg
// Description : Shared types and default constants for the mouse event
//               path (event controller, cursor drawer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mouse_pkg;

   // Default configuration shared by mouse_event_ctrl and draw_mouse
   localparam int MOUSE_N_BTN        = 2;
   localparam int MOUSE_POS_W        = 12;
   localparam int MOUSE_DEBOUNCE_CYC = 16;
   localparam int MOUSE_H_MAX        = 799;
   localparam int MOUSE_V_MAX        = 599;

   // Per-button debounce state, explicitly encoded on two bits
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_PEND = 2'd1,
      HELD       = 2'd2,
      REL_PEND   = 2'd3
   } btn_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Single-button 2-FF synchroniser plus debounce FSM with a
//               saturating stability counter. Emits debounced level and
//               one-cycle press/release pulses, plus press_pre, which is
//               the value btn_press will take on the next clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
   import mouse_pkg::*;
#(
   parameter int DEBOUNCE_CYC = MOUSE_DEBOUNCE_CYC
)
(
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic press_pre
);

   localparam int                c_cnt_w   = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYC);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;

   logic               r_meta;
   logic               r_sync;
   btn_state_t         r_state;
   btn_state_t         w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_nxt;
   logic [c_cnt_w-1:0] w_cnt_inc;
   logic               r_rel_pre;

   // Bring the raw level into the clock domain through two flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= btn_raw;
         r_sync <= r_meta;
      end
   end

   // Counter never wraps: it holds at the acceptance threshold
   assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

   // Next-state logic: a level change is accepted only after DEBOUNCE_CYC
   // consecutive agreeing samples; any contrary sample aborts the attempt
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (r_sync) begin
               w_state_nxt = PRESS_PEND;
               w_cnt_nxt   = c_cnt_one;
            end
         end
         PRESS_PEND: begin
            if (r_sync) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == c_cnt_max) begin
                  w_state_nxt = HELD;
               end
            end else begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = c_cnt_zero;
            end
         end
         HELD: begin
            if (!r_sync) begin
               w_state_nxt = REL_PEND;
               w_cnt_nxt   = c_cnt_one;
            end
         end
         REL_PEND: begin
            if (!r_sync) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == c_cnt_max) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = c_cnt_zero;
               end
            end else begin
               w_state_nxt = HELD;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = c_cnt_zero;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= c_cnt_zero;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Edge flags are registered twice so the pulses appear the cycle after
   // the debounced transition; press_pre exposes the first stage so the
   // event capture can load in the same cycle as btn_press
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         press_pre   <= 1'b0;
         r_rel_pre   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         press_pre   <= (r_state == PRESS_PEND) && (w_state_nxt == HELD);
         r_rel_pre   <= (r_state == REL_PEND) && (w_state_nxt == IDLE);
         btn_press   <= press_pre;
         btn_release <= r_rel_pre;
      end
   end

   assign btn_level = (r_state == HELD) || (r_state == REL_PEND);

endmodule

`default_nettype wire

// File: rtl/mouse_event_ctrl.sv
// ============================================================================
// Module      : mouse_event_ctrl
// Description : Button debounce, frame-latched cursor position and click
//               event capture with valid/ready handoff to the game FSM.
//               Optional macro MOUSE_CLAMP_EN clamps the stable position to
//               H_MAX/V_MAX before frame latch and event capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mouse_event_ctrl
   import mouse_pkg::*;
#(
   parameter int N_BTN        = MOUSE_N_BTN,
   parameter int POS_W        = MOUSE_POS_W,
   parameter int DEBOUNCE_CYC = MOUSE_DEBOUNCE_CYC,
   parameter int H_MAX        = MOUSE_H_MAX,
   parameter int V_MAX        = MOUSE_V_MAX
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [POS_W-1:0] xpos_in,
   input  logic [POS_W-1:0] ypos_in,
   input  logic             vsync,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [POS_W-1:0] xpos_out,
   output logic [POS_W-1:0] ypos_out,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [N_BTN-1:0] evt_btn,
   output logic [POS_W-1:0] evt_x,
   output logic [POS_W-1:0] evt_y,
   output logic             evt_ovf,
   input  logic             evt_ovf_clr
);

`ifdef MOUSE_CLAMP_EN
   localparam logic c_clamp_en = 1'b1;
`else
   localparam logic c_clamp_en = 1'b0;
`endif
   localparam logic [POS_W-1:0] c_x_lim = POS_W'(H_MAX);
   localparam logic [POS_W-1:0] c_y_lim = POS_W'(V_MAX);

   logic [N_BTN-1:0] w_press_pre;
   logic [POS_W-1:0] r_x_d;
   logic [POS_W-1:0] r_y_d;
   logic [POS_W-1:0] r_x_stab;
   logic [POS_W-1:0] r_y_stab;
   logic [POS_W-1:0] w_x_pos;
   logic [POS_W-1:0] w_y_pos;
   logic             r_vs_d;
   logic             r_vs_rise;
   logic             w_any_press;
   logic             w_drop;

   // One debouncer per button
   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_deb (
         .clk         (clk),
         .rst         (rst),
         .btn_raw     (btn_raw[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i]),
         .press_pre   (w_press_pre[i])
      );
   end

   // Accept a new position only when two consecutive samples agree, so a
   // multi-bit value caught mid-update is never used
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x_d    <= '0;
         r_y_d    <= '0;
         r_x_stab <= '0;
         r_y_stab <= '0;
      end else begin
         r_x_d <= xpos_in;
         r_y_d <= ypos_in;
         if ((xpos_in == r_x_d) && (ypos_in == r_y_d)) begin
            r_x_stab <= xpos_in;
            r_y_stab <= ypos_in;
         end
      end
   end

   // Optional clamp; without the macro the limits fold away as constants
   assign w_x_pos = (c_clamp_en && (r_x_stab > c_x_lim)) ? c_x_lim : r_x_stab;
   assign w_y_pos = (c_clamp_en && (r_y_stab > c_y_lim)) ? c_y_lim : r_y_stab;

   // Registered vsync rising-edge detect, then latch the position so the
   // cursor drawer sees one value for the whole frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vs_d    <= 1'b0;
         r_vs_rise <= 1'b0;
         xpos_out  <= '0;
         ypos_out  <= '0;
      end else begin
         r_vs_d    <= vsync;
         r_vs_rise <= vsync & ~r_vs_d;
         if (r_vs_rise) begin
            xpos_out <= w_x_pos;
            ypos_out <= w_y_pos;
         end
      end
   end

   assign w_any_press = |w_press_pre;
   assign w_drop      = w_any_press && evt_valid && !evt_ready;

   // Capture a click when the slot is free or being consumed this cycle;
   // payload is left untouched on consumption
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         evt_valid <= 1'b0;
         evt_btn   <= '0;
         evt_x     <= '0;
         evt_y     <= '0;
      end else if (w_any_press && (!evt_valid || evt_ready)) begin
         evt_valid <= 1'b1;
         evt_btn   <= w_press_pre;
         evt_x     <= w_x_pos;
         evt_y     <= w_y_pos;
      end else if (evt_valid && evt_ready) begin
         evt_valid <= 1'b0;
      end
   end

   // Sticky drop flag; a drop in the clearing cycle keeps it set
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         evt_ovf <= 1'b0;
      end else if (w_drop) begin
         evt_ovf <= 1'b1;
      end else if (evt_ovf_clr) begin
         evt_ovf <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mouse_event_ctrl.sv
// ============================================================================
// Module      : tb_mouse_event_ctrl
// Description : Directed self-checking bench for mouse_event_ctrl with an
//               expected-event queue checked at each consumer handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mouse_event_ctrl;

   localparam int N_BTN = 2;
   localparam int POS_W = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_BTN-1:0] btn_raw;
   logic [POS_W-1:0] xpos_in;
   logic [POS_W-1:0] ypos_in;
   logic             vsync;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [POS_W-1:0] xpos_out;
   logic [POS_W-1:0] ypos_out;
   logic             evt_valid;
   logic             evt_ready;
   logic [N_BTN-1:0] evt_btn;
   logic [POS_W-1:0] evt_x;
   logic [POS_W-1:0] evt_y;
   logic             evt_ovf;
   logic             evt_ovf_clr;

   typedef struct packed {
      logic [N_BTN-1:0] btn;
      logic [POS_W-1:0] x;
      logic [POS_W-1:0] y;
   } evt_t;

   evt_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   press_cnt [N_BTN] = '{default: 0};
   int   rel_cnt   [N_BTN] = '{default: 0};

   mouse_event_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .xpos_in     (xpos_in),
      .ypos_in     (ypos_in),
      .vsync       (vsync),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .xpos_out    (xpos_out),
      .ypos_out    (ypos_out),
      .evt_valid   (evt_valid),
      .evt_ready   (evt_ready),
      .evt_btn     (evt_btn),
      .evt_x       (evt_x),
      .evt_y       (evt_y),
      .evt_ovf     (evt_ovf),
      .evt_ovf_clr (evt_ovf_clr)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle
   always @(negedge clk) begin
      for (int b = 0; b < N_BTN; b++) begin
         if (btn_press[b])   press_cnt[b] = press_cnt[b] + 1;
         if (btn_release[b]) rel_cnt[b]   = rel_cnt[b] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_evt(input logic [N_BTN-1:0] b, input logic [POS_W-1:0] x,
                           input logic [POS_W-1:0] y);
      evt_t e;
      e.btn = b;
      e.x   = x;
      e.y   = y;
      exp_q.push_back(e);
   endtask

   // Consume the pending event for one cycle and check it against the queue
   task automatic accept_evt(input string tag);
      evt_t e;
      chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_btn"}, 32'(evt_btn), 32'(e.btn));
         chk({tag, "_x"},   32'(evt_x),   32'(e.x));
         chk({tag, "_y"},   32'(evt_y),   32'(e.y));
      end
      evt_ready = 1'b1;
      cycles(1);
      evt_ready = 1'b0;
      chk({tag, "_cleared"}, 32'(evt_valid), 32'd0);
   endtask

   initial begin
      int first_cyc;
      int n_press;
      logic [N_BTN-1:0] first_pat;
      int p0, r0, r1;

      rst         = 1'b1;
      btn_raw     = 2'b11;
      xpos_in     = '0;
      ypos_in     = '0;
      vsync       = 1'b0;
      evt_ready   = 1'b0;
      evt_ovf_clr = 1'b0;
      #2 rst = 1'b0;

      // Reset held with both buttons raw-high
      cycles(5);
      chk("rst_level",   32'(btn_level),   32'd0);
      chk("rst_press",   32'(btn_press),   32'd0);
      chk("rst_release", 32'(btn_release), 32'd0);
      chk("rst_xpos",    32'(xpos_out),    32'd0);
      chk("rst_ypos",    32'(ypos_out),    32'd0);
      chk("rst_valid",   32'(evt_valid),   32'd0);
      chk("rst_evt_btn", 32'(evt_btn),     32'd0);
      chk("rst_ovf",     32'(evt_ovf),     32'd0);

      // Release reset: both presses land together after 2+16+1 cycles
      rst = 1'b1;
      push_evt(2'b11, 12'd0, 12'd0);
      first_cyc = 0;
      n_press   = 0;
      first_pat = '0;
      for (int c = 1; c <= 30; c++) begin
         cycles(1);
         if (btn_press != '0) begin
            n_press++;
            if (first_cyc == 0) begin
               first_cyc = c;
               first_pat = btn_press;
            end
         end
      end
      chk("latency_cycle", 32'(first_cyc), 32'd19);
      chk("latency_mask",  32'(first_pat), 32'd3);
      chk("latency_count", 32'(n_press),   32'd1);
      accept_evt("simul_evt");

      // Release both buttons
      r0 = rel_cnt[0];
      r1 = rel_cnt[1];
      btn_raw = 2'b00;
      cycles(30);
      chk("release_b0", 32'(rel_cnt[0] - r0), 32'd1);
      chk("release_b1", 32'(rel_cnt[1] - r1), 32'd1);
      chk("release_level", 32'(btn_level), 32'd0);

      // Bouncing left button, then stable high
      xpos_in = 12'd123;
      ypos_in = 12'd45;
      cycles(3);
      p0 = press_cnt[0];
      r0 = rel_cnt[0];
      for (int k = 0; k < 12; k++) begin
         btn_raw[0] = (k % 2 == 0);
         cycles(5);
      end
      btn_raw[0] = 1'b1;
      push_evt(2'b01, 12'd123, 12'd45);
      cycles(30);
      chk("bounce_press",   32'(press_cnt[0] - p0), 32'd1);
      chk("bounce_release", 32'(rel_cnt[0] - r0),   32'd0);
      chk("bounce_level",   32'(btn_level),         32'd1);
      chk("bounce_valid",   32'(evt_valid),         32'd1);

      // Right press while left event pending: dropped, overflow flagged
      btn_raw = 2'b11;
      cycles(30);
      chk("ovf_valid", 32'(evt_valid), 32'd1);
      chk("ovf_btn",   32'(evt_btn),   32'd1);
      chk("ovf_x",     32'(evt_x),     32'd123);
      chk("ovf_y",     32'(evt_y),     32'd45);
      chk("ovf_set",   32'(evt_ovf),   32'd1);
      evt_ovf_clr = 1'b1;
      cycles(1);
      evt_ovf_clr = 1'b0;
      chk("ovf_clr", 32'(evt_ovf), 32'd0);

      // Clear coincident with a new drop: set wins
      btn_raw = 2'b01;
      cycles(30);
      btn_raw = 2'b11;
      cycles(18);
      evt_ovf_clr = 1'b1;
      cycles(1);
      evt_ovf_clr = 1'b0;
      chk("ovf_clr_vs_drop", 32'(evt_ovf), 32'd1);
      chk("ovf_btn_kept",    32'(evt_btn), 32'd1);
      accept_evt("left_evt");
      btn_raw = 2'b00;
      cycles(30);

      // Frame latch: position only moves on a vsync rise
      xpos_in = 12'd100;
      ypos_in = 12'd50;
      cycles(3);
      vsync = 1'b1;
      cycles(2);
      vsync = 1'b0;
      cycles(2);
      chk("frame_x100", 32'(xpos_out), 32'd100);
      chk("frame_y50",  32'(ypos_out), 32'd50);
      xpos_in = 12'd200;
      cycles(5);
      chk("frame_hold", 32'(xpos_out), 32'd100);
      vsync = 1'b1;
      cycles(2);
      vsync = 1'b0;
      cycles(2);
      chk("frame_x200", 32'(xpos_out), 32'd200);

      // Out-of-range x through the frame latch
      xpos_in = 12'd900;
      cycles(3);
      vsync = 1'b1;
      cycles(2);
      vsync = 1'b0;
      cycles(2);
`ifdef MOUSE_CLAMP_EN
      chk("clamp_x", 32'(xpos_out), 32'd799);
`else
      chk("noclamp_x", 32'(xpos_out), 32'd900);
`endif
      chk("no_stray_evt", 32'(evt_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
